grid_port_arbiter: RTL

GRID_PORT_ARBITER -- requirements
Module: grid_port_arbiter

---
 rtl/grid_pkg.sv | 14 +
 rtl/rd_valid_pipe.sv | 22 ++
 rtl/grid_port_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/grid_pkg.sv
// Shared definitions for the pixel-grid port arbiter.
//   GRID_DEPTH   : words in the pixel OCM
//   GRID_ADDR_W  : OCM word-address width
//   grid_state_e : arbiter FSM states
package grid_pkg;
    localparam int GRID_DEPTH  = 1024;
    localparam int GRID_ADDR_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_DONE
    } grid_state_e;
endpackage

// File: rtl/rd_valid_pipe.sv
// Read-valid delay line: a read granted at edge T comes back as a valid
// flag in cycle T+STAGES (grant register + registered RAM). STAGES >= 2.
//   clk, rst_n : clock, async active-low reset
//   vld_in     : read accepted this cycle
//   vld_out    : read data valid this cycle
module rd_valid_pipe #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic vld_in,
    output logic vld_out
);
    logic [STAGES:1] vld_pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_pipe <= '0;
        else        vld_pipe <= {vld_pipe[STAGES-1:1], vld_in};
    end

    assign vld_out = vld_pipe[STAGES];
endmodule

// File: rtl/grid_port_arbiter.sv
// Owns OCM port B of the pixel grid and multiplexes three clients onto it:
// a full-grid clear sweep, the Avalon-MM slave (search engine, Run=1) and
// the paint writer (Run=0). All ocm_* outputs are registered; ocm_q is a
// 1-cycle registered RAM output, so Avalon reads return two cycles after
// acceptance.
//   Clk, Reset_n          : clock, async active-low reset
//   Run                   : grid owner select (1 = Avalon, 0 = paint)
//   clear_req             : one-cycle request to fill the grid with CLEAR_VAL
//   paint_*               : paint write request / ack
//   avl_*                 : Avalon-MM slave
//   ocm_*                 : OCM port B
//   busy, clear_done      : sweep status
module grid_port_arbiter
    import grid_pkg::*;
#(
    parameter int          ADDR_W    = GRID_ADDR_W,
    parameter int          DEPTH     = GRID_DEPTH,
    parameter logic [31:0] CLEAR_VAL = 32'h0000_0000
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Run,
    input  logic              clear_req,
    input  logic              paint_we,
    input  logic [ADDR_W-1:0] paint_addr,
    input  logic [3:0]        paint_be,
    input  logic [31:0]       paint_data,
    output logic              paint_ack,
    input  logic              avl_cs,
    input  logic              avl_read,
    input  logic              avl_write,
    input  logic [ADDR_W-1:0] avl_address,
    input  logic [3:0]        avl_byteenable,
    input  logic [31:0]       avl_writedata,
    output logic              avl_waitrequest,
    output logic [31:0]       avl_readdata,
    output logic              avl_readdatavalid,
    output logic [ADDR_W-1:0] ocm_addr,
    output logic [3:0]        ocm_be,
    output logic [31:0]       ocm_data,
    output logic              ocm_wren,
    output logic              ocm_rden,
    input  logic [31:0]       ocm_q,
    output logic              busy,
    output logic              clear_done
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    grid_state_e       state, state_nx;
    logic [ADDR_W-1:0] cnt, cnt_nx;
    logic              pend, pend_nx;
    logic              avl_acc, rd_acc;

    // Avalon only sees the port while it owns the grid and no sweep runs.
    // A pending clear with Run=1 does not stall Avalon; it waits for Run=0.
    assign avl_waitrequest = !(Run && state == ST_IDLE);
    assign avl_acc         = avl_cs && (avl_read || avl_write) && !avl_waitrequest;
    assign rd_acc          = avl_acc && !avl_write;   // read+write counts as write

    // A pending clear outranks paint, so paint is held off while pend=1.
    assign paint_ack  = paint_we && !Run && state == ST_IDLE && !pend;
    assign busy       = (state == ST_CLEAR);
    assign clear_done = (state == ST_DONE);
    assign avl_readdata = ocm_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            pend  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            pend  <= pend_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        pend_nx  = pend;
        case (state)
            ST_IDLE: begin
                if (clear_req) pend_nx = 1'b1;
                if (pend && !Run) begin
                    state_nx = ST_CLEAR;
                    cnt_nx   = '0;
                    pend_nx  = 1'b0;
                end
            end
            ST_CLEAR: begin
                cnt_nx = cnt + 1'b1;
                if (cnt == LAST) begin
                    state_nx = ST_DONE;
                    cnt_nx   = '0;
                end
            end
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // Port-B grant register: one access per cycle, strobes default low.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ocm_wren <= 1'b0;
            ocm_rden <= 1'b0;
            ocm_addr <= '0;
            ocm_be   <= '0;
            ocm_data <= '0;
        end else begin
            ocm_wren <= 1'b0;
            ocm_rden <= 1'b0;
            if (state == ST_CLEAR) begin
                ocm_wren <= 1'b1;
                ocm_addr <= cnt;
                ocm_be   <= 4'hF;
                ocm_data <= CLEAR_VAL;
            end else if (avl_acc) begin
                ocm_addr <= avl_address;
                if (avl_write) begin
                    ocm_wren <= 1'b1;
                    ocm_be   <= avl_byteenable;
                    ocm_data <= avl_writedata;
                end else begin
                    ocm_rden <= 1'b1;
                    ocm_be   <= 4'hF;
                end
            end else if (paint_ack) begin
                ocm_wren <= 1'b1;
                ocm_addr <= paint_addr;
                ocm_be   <= paint_be;
                ocm_data <= paint_data;
            end
        end
    end

    rd_valid_pipe #(.STAGES(2)) u_rd_valid_pipe (
        .clk    (Clk),
        .rst_n  (Reset_n),
        .vld_in (rd_acc),
        .vld_out(avl_readdatavalid)
    );
endmodule
